// File: rtl/md5_board_pkg.sv
// Shared types and constants for the MD5 board housekeeping controller.
// Holds the sequencer states, default cycle counts and a popcount helper.
package md5_board_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    QUALIFY   = 2'd2,
    RUN       = 2'd3
  } board_state_e;

  localparam int unsigned LOCK_CYCLES_DFLT = 1024;
  localparam int unsigned STRETCH_DFLT     = 15000000;
  localparam int unsigned HB_DFLT          = 75000000;

  // Widest vector popcount accepts; narrower callers zero-extend.
  localparam int unsigned POP_MAX_W = 64;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    logic [POP_MAX_W-1:0] w;
    int unsigned          n;
    w = v;
    n = 0;
    for (int unsigned k = 0; k < POP_MAX_W; k++) begin
      n = n + 32'(w[0]);
      w = w >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/md5_board_ctrl_if.sv
// Board-side signal bundle between the housekeeping controller and the board top.
// slave is the controller view; master is the board/stimulus view.
interface md5_board_ctrl_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned NUM_LEDS  = 4,
  parameter int unsigned COUNT_W   = 16
);

  logic                 locked;
  logic [NUM_CORES-1:0] match_in;
  logic                 clear_in;
  logic                 core_reset;
  logic                 led0_r;
  logic                 led0_b;
  logic                 match_led;
  logic                 heartbeat;
  logic [NUM_LEDS-1:0]  led;
  logic [COUNT_W-1:0]   match_count;

  modport master (
    output locked, match_in, clear_in,
    input  core_reset, led0_r, led0_b, match_led, heartbeat, led, match_count
  );

  modport slave (
    input  locked, match_in, clear_in,
    output core_reset, led0_r, led0_b, match_led, heartbeat, led, match_count
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with asynchronous active-low reset to zero.
// Used both for the clock-wizard lock and for the reset deassert path.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/md5_board_ctrl.sv
// Board housekeeping for multi-core MD5 tops: lock-qualified core reset sequencing,
// sticky per-core match LEDs, stretched match indicator, heartbeat and match counter.
module md5_board_ctrl
  import md5_board_pkg::*;
#(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned NUM_LEDS       = 4,
  parameter int unsigned LOCK_CYCLES    = LOCK_CYCLES_DFLT,
  parameter int unsigned STRETCH_CYCLES = STRETCH_DFLT,
  parameter int unsigned HB_CYCLES      = HB_DFLT,
  parameter int unsigned COUNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  md5_board_ctrl_if.slave  bus
);

  localparam int unsigned LK_W  = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned ST_W  = $clog2(STRETCH_CYCLES + 1);
  localparam int unsigned HB_W  = $clog2(HB_CYCLES + 1);
  localparam int unsigned PC_W  = $clog2(NUM_CORES + 1);
  localparam int unsigned SUM_W = ((COUNT_W > PC_W) ? COUNT_W : PC_W) + 1;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic rst_n_s;
  logic locked_s;

  board_state_e         state_q,      state_d;
  logic [LK_W-1:0]      lk_cnt_q,     lk_cnt_d;
  logic                 core_reset_q, core_reset_d;
  logic [NUM_CORES-1:0] match_q,      match_d;
  logic [NUM_LEDS-1:0]  led_q,        led_d;
  logic [COUNT_W-1:0]   cnt_q,        cnt_d;
  logic [ST_W-1:0]      st_cnt_q,     st_cnt_d;
  logic                 match_led_q,  match_led_d;
  logic [HB_W-1:0]      hb_cnt_q,     hb_cnt_d;
  logic                 hb_q,         hb_d;

  logic [NUM_CORES-1:0] rise;
  logic [NUM_LEDS-1:0]  led_set;
  logic [PC_W-1:0]      pop;
  logic [COUNT_W-1:0]   cnt_base;
  logic [SUM_W-1:0]     cnt_sum;

  // Reset asserts asynchronously, releases two clocks after the button lets go.
  sync_2ff #(.WIDTH(1)) u_rst_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (1'b1),
    .q_o   (rst_n_s)
  );

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n_s),
    .d_i   (bus.locked),
    .q_o   (locked_s)
  );

  // Lock qualification sequencer.
  always_comb begin
    state_d  = state_q;
    lk_cnt_d = '0;
    case (state_q)
      HOLD:      state_d = WAIT_LOCK;
      WAIT_LOCK: if (locked_s) state_d = QUALIFY;
      QUALIFY: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (lk_cnt_q == LK_W'(LOCK_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          lk_cnt_d = lk_cnt_q + LK_W'(1);
        end
      end
      RUN:       if (!locked_s) state_d = WAIT_LOCK;
      default:   state_d = HOLD;
    endcase
    core_reset_d = (state_d != RUN);
  end

  // Cores above the last LED fold onto it; LEDs beyond the core count stay dark.
  for (genvar l = 0; l < NUM_LEDS; l++) begin : g_led_map
    if (l >= NUM_CORES) begin : g_none
      assign led_set[l] = 1'b0;
    end else if (l < NUM_LEDS - 1) begin : g_one
      assign led_set[l] = rise[l];
    end else begin : g_fold
      assign led_set[l] = |rise[NUM_CORES-1:l];
    end
  end

  // Match edge detect, sticky LEDs and saturating counter.
  always_comb begin
    match_d = core_reset_q ? '0 : bus.match_in;
    rise    = core_reset_q ? '0 : (bus.match_in & ~match_q);

    led_d = (bus.clear_in || core_reset_q) ? '0 : led_q;
    led_d = led_d | led_set;

    pop      = PC_W'(popcount(POP_MAX_W'(rise)));
    cnt_base = (bus.clear_in || core_reset_q) ? '0 : cnt_q;
    cnt_sum  = SUM_W'(cnt_base) + SUM_W'(pop);
    cnt_d    = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : COUNT_W'(cnt_sum);
  end

  // Retriggerable match stretcher and RUN-only heartbeat.
  always_comb begin
    st_cnt_d = st_cnt_q;
    if (core_reset_q) begin
      st_cnt_d = '0;
    end else if (|rise) begin
      st_cnt_d = ST_W'(STRETCH_CYCLES);
    end else if (st_cnt_q != '0) begin
      st_cnt_d = st_cnt_q - ST_W'(1);
    end
    match_led_d = (st_cnt_d != '0);

    hb_cnt_d = '0;
    hb_d     = 1'b0;
    if ((state_q == RUN) && (state_d == RUN)) begin
      if (hb_cnt_q == HB_W'(HB_CYCLES - 1)) begin
        hb_d = ~hb_q;
      end else begin
        hb_cnt_d = hb_cnt_q + HB_W'(1);
        hb_d     = hb_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q      <= HOLD;
      lk_cnt_q     <= '0;
      core_reset_q <= 1'b1;
      match_q      <= '0;
      led_q        <= '0;
      cnt_q        <= '0;
      st_cnt_q     <= '0;
      match_led_q  <= 1'b0;
      hb_cnt_q     <= '0;
      hb_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      lk_cnt_q     <= lk_cnt_d;
      core_reset_q <= core_reset_d;
      match_q      <= match_d;
      led_q        <= led_d;
      cnt_q        <= cnt_d;
      st_cnt_q     <= st_cnt_d;
      match_led_q  <= match_led_d;
      hb_cnt_q     <= hb_cnt_d;
      hb_q         <= hb_d;
    end
  end

  assign bus.core_reset  = core_reset_q;
  assign bus.led0_r      = core_reset_q;
  assign bus.led0_b      = ~locked_s;
  assign bus.match_led   = match_led_q;
  assign bus.heartbeat   = hb_q;
  assign bus.led         = led_q;
  assign bus.match_count = cnt_q;

endmodule

// File: tb/tb_md5_board_ctrl.sv
// Directed bench for md5_board_ctrl with small cycle constants so every
// sequencing, stretch, saturation and reset corner is reachable quickly.
module tb_md5_board_ctrl;

  localparam int unsigned NC = 6;
  localparam int unsigned NL = 4;
  localparam int unsigned LC = 4;
  localparam int unsigned SC = 8;
  localparam int unsigned HC = 16;
  localparam int unsigned CW = 3;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  md5_board_ctrl_if #(.NUM_CORES(NC), .NUM_LEDS(NL), .COUNT_W(CW)) bus ();

  md5_board_ctrl #(
    .NUM_CORES      (NC),
    .NUM_LEDS       (NL),
    .LOCK_CYCLES    (LC),
    .STRETCH_CYCLES (SC),
    .HB_CYCLES      (HC),
    .COUNT_W        (CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_core_reset"},  32'(bus.core_reset),  32'd1);
    check_eq({tag, "_led0_r"},      32'(bus.led0_r),      32'd1);
    check_eq({tag, "_led0_b"},      32'(bus.led0_b),      32'd1);
    check_eq({tag, "_match_led"},   32'(bus.match_led),   32'd0);
    check_eq({tag, "_heartbeat"},   32'(bus.heartbeat),   32'd0);
    check_eq({tag, "_led"},         32'(bus.led),         32'd0);
    check_eq({tag, "_match_count"}, 32'(bus.match_count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_lock;
    int t_rel;
    int n_rel;

    bus.locked   = 1'b1;
    bus.match_in = '0;
    bus.clear_in = 1'b0;
    #2 reset_n = 1'b0;
    tick(3);
    check_reset_outputs("rst");

    // Lock qualification: locked held high through reset release.
    reset_n = 1'b1;
    t_lock = -1;
    t_rel  = -1;
    for (int c = 1; c <= 40 && t_rel < 0; c++) begin
      tick();
      if (t_lock < 0 && bus.led0_b == 1'b0) t_lock = c;
      if (bus.core_reset == 1'b0) t_rel = c;
    end
    check_eq("lock_sync_cycle", 32'(t_lock), 32'd4);
    check_eq("release_latency", 32'(t_rel - t_lock), 32'(LC + 1));
    check_eq("led0_r_released", 32'(bus.led0_r), 32'd0);

    // Heartbeat toggles HB_CYCLES after release.
    tick(HC - 1);
    check_eq("hb_before_toggle", 32'(bus.heartbeat), 32'd0);
    tick();
    check_eq("hb_toggle", 32'(bus.heartbeat), 32'd1);

    // Lock lost in RUN: two sync stages, then core reset on the next clock.
    bus.locked = 1'b0;
    tick(2);
    check_eq("run_drop_still_released", 32'(bus.core_reset), 32'd0);
    tick();
    check_eq("run_drop_core_reset", 32'(bus.core_reset), 32'd1);
    check_eq("run_drop_heartbeat",  32'(bus.heartbeat),  32'd0);

    // Lock returns, then glitches for one cycle during qualification.
    bus.locked = 1'b1;
    tick(2);
    check_eq("relock_sync", 32'(bus.led0_b), 32'd0);
    bus.locked = 1'b0;
    tick();
    bus.locked = 1'b1;
    n_rel = -1;
    for (int c = 1; c <= 30 && n_rel < 0; c++) begin
      tick();
      if (bus.core_reset == 1'b0) n_rel = c;
    end
    check_eq("glitch_requalify", 32'(n_rel), 32'd7);

    // Match fold: core 5 lands on the last LED, core 1 on its own.
    bus.match_in = 6'b100000;
    tick();
    bus.match_in = 6'b000000;
    tick();
    bus.match_in = 6'b000010;
    tick();
    check_eq("fold_led",   32'(bus.led),         32'b1010);
    check_eq("fold_count", 32'(bus.match_count), 32'd2);
    tick(3);
    check_eq("hold_no_recount", 32'(bus.match_count), 32'd2);
    check_eq("match_led_lit",   32'(bus.match_led),   32'd1);

    // Stretch retrigger: rise in cycle 0 and again in cycle 5.
    tick(10);
    check_eq("stretch_idle", 32'(bus.match_led), 32'd0);
    bus.match_in = 6'b000011;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_eq($sformatf("stretch_k%0d", k), 32'(bus.match_led), 32'((k >= 1 && k <= 13) ? 1 : 0));
      if (k == 5) bus.match_in = 6'b000111;
    end
    check_eq("stretch_count", 32'(bus.match_count), 32'd4);
    check_eq("stretch_led",   32'(bus.led),         32'b1111);

    // Clear with no concurrent edge.
    bus.clear_in = 1'b1;
    tick();
    bus.clear_in = 1'b0;
    check_eq("clear_count", 32'(bus.match_count), 32'd0);
    check_eq("clear_led",   32'(bus.led),         32'd0);
    bus.match_in = '0;
    tick();

    // Saturation after nine single edges.
    for (int e = 0; e < 9; e++) begin
      bus.match_in = 6'b001000;
      tick();
      bus.match_in = 6'b000000;
      tick();
    end
    check_eq("sat_count", 32'(bus.match_count), 32'd7);
    check_eq("sat_led",   32'(bus.led),         32'b1000);

    // Clear coinciding with a two-core rise: the edges win.
    bus.match_in = 6'b000011;
    bus.clear_in = 1'b1;
    tick();
    bus.clear_in = 1'b0;
    check_eq("clear_set_count", 32'(bus.match_count), 32'd2);
    check_eq("clear_set_led",   32'(bus.led),         32'b0011);

    // Three simultaneous folded edges.
    bus.match_in = '0;
    tick();
    bus.match_in = 6'b111000;
    tick();
    check_eq("multi_count", 32'(bus.match_count), 32'd5);
    check_eq("multi_led",   32'(bus.led),         32'b1011);
    check_eq("pre_rst_match_led", 32'(bus.match_led), 32'd1);

    // Asynchronous reset mid-operation, sampled before any clock edge.
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick(2);
    check_reset_outputs("held_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
